// File: rtl/sequence_gen.sv
// Serial pattern transmitter: latches a pattern field on start and shifts it out MSB-first,
// one bit per divided-clock tick, with optional seamless repeat and a running "111" event count.
module sequence_gen #(
    parameter int DIV = 4,
    parameter int PW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [PW-1:0] pattern,
    input  logic [3:0]    len,
    input  logic          rpt,
    output logic          out,
    output logic          valid,
    output logic          tick,
    output logic          busy,
    output logic          done,
    output logic [1:0]    state,
    output logic [7:0]    hits
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [3:0]    PW_L    = 4'(PW);

    logic [CW-1:0] cnt_q, cnt_d;
    state_e        state_q, state_d;
    logic [PW-1:0] shadow_q, shadow_d;
    logic [3:0]    len_q, len_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [1:0]    hist_q, hist_d;
    logic [7:0]    hits_q, hits_d;
    logic          out_q, out_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [15:0]   shadow_ext;
    logic [3:0]    len_clamped;
    logic          emit;
    logic [3:0]    emit_idx;
    logic          emit_bit;

    // Divider free-runs independently of the FSM so tick phase is fixed from reset.
    always_comb begin
        cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
    end

    assign tick        = (cnt_q == CNT_MAX);
    assign shadow_ext  = {{(16 - PW){1'b0}}, shadow_q};
    assign len_clamped = (len > PW_L) ? PW_L : len;

    // Handshake: start is a level request that is consumed only on an edge where the FSM is
    // in IDLE and len is non-zero; at all other times it is ignored and never queued.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        len_d    = len_q;
        bitcnt_d = bitcnt_q;
        hist_d   = hist_q;
        hits_d   = hits_q;
        out_d    = out_q;
        valid_d  = valid_q;
        emit     = 1'b0;
        emit_idx = len_q - 4'd1;
        emit_bit = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && (len != 4'd0)) begin
                    shadow_d = pattern;
                    len_d    = len_clamped;
                    hist_d   = 2'b00;
                    hits_d   = 8'd0;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (tick) begin
                    emit     = 1'b1;
                    emit_idx = len_q - 4'd1;
                    bitcnt_d = len_q - 4'd1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (bitcnt_q != 4'd0) begin
                        emit     = 1'b1;
                        emit_idx = bitcnt_q - 4'd1;
                        bitcnt_d = bitcnt_q - 4'd1;
                    end else if (rpt) begin
                        emit     = 1'b1;
                        emit_idx = len_q - 4'd1;
                        bitcnt_d = len_q - 4'd1;
                    end else begin
                        out_d   = 1'b0;
                        valid_d = 1'b0;
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Repeat boundaries keep the history, so a run of 1s spanning two passes still counts.
        if (emit) begin
            emit_bit = shadow_ext[emit_idx];
            out_d    = emit_bit;
            valid_d  = 1'b1;
            hist_d   = {hist_q[0], emit_bit};
            if (emit_bit && (hist_q == 2'b11) && (hits_q != 8'hFF)) begin
                hits_d = hits_q + 8'd1;
            end
        end

        busy_d = (state_d == ST_LOAD) || (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            len_q    <= 4'd0;
            bitcnt_q <= 4'd0;
            hist_q   <= 2'b00;
            hits_q   <= 8'd0;
            out_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            shadow_q <= shadow_d;
            len_q    <= len_d;
            bitcnt_q <= bitcnt_d;
            hist_q   <= hist_d;
            hits_q   <= hits_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign state = state_q;
    assign hits  = hits_q;

endmodule

// File: tb/tb_sequence_gen.sv
// Bench for sequence_gen: directed and randomized transfers checked against a bit-list model
// built from the pattern field, the clamped length and the number of repeated passes.
module tb_sequence_gen;

    localparam int DIV = 4;
    localparam int PW  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [PW-1:0] pattern;
    logic [3:0]    len;
    logic          rpt;
    logic          out;
    logic          valid;
    logic          tick;
    logic          busy;
    logic          done;
    logic [1:0]    state;
    logic [7:0]    hits;

    int n_cmp = 0;
    int n_bad = 0;

    logic [0:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    sequence_gen #(.DIV(DIV), .PW(PW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .pattern(pattern),
        .len    (len),
        .rpt    (rpt),
        .out    (out),
        .valid  (valid),
        .tick   (tick),
        .busy   (busy),
        .done   (done),
        .state  (state),
        .hits   (hits)
    );

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected bit stream: field pattern[l-1:0] MSB-first, repeated reps times;
    // hits = number of bits that end a run of at least three consecutive 1s.
    task automatic model_load(input logic [PW-1:0] pat, input int ln, input int reps,
                              output int exp_hits);
        int l;
        int ones;
        logic b;
        l = (ln > PW) ? PW : ln;
        ones = 0;
        exp_hits = 0;
        exp_q.delete();
        for (int r = 0; r < reps; r++) begin
            for (int i = l - 1; i >= 0; i--) begin
                b = pat[i];
                exp_q.push_back(b);
                ones = b ? ones + 1 : 0;
                if (ones >= 3 && exp_hits < 255) exp_hits++;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic check_first_tick(input string name);
        int k;
        for (k = 1; k <= DIV + 4; k++) begin
            @(negedge clk);
            check({name, "_done_quiet"}, done, 0);
            if (tick) break;
        end
        check({name, "_first_tick_edge"}, k + 1, DIV);
    endtask

    task automatic send(input string name, input logic [PW-1:0] pat, input int ln,
                        input int nrep, input bit poke, input int abort_at);
        int l, exp_hits, emitted, held, cyc, lat;
        logic last_b;
        bit pend, fin;
        l = (ln > PW) ? PW : ln;
        model_load(pat, ln, nrep + 1, exp_hits);
        pattern = pat;
        len     = 4'(ln);
        start   = 1'b1;
        rpt     = 1'($urandom_range(0, 1));
        @(negedge clk);
        start   = 1'b0;
        pattern = PW'($urandom);
        len     = 4'($urandom);
        check({name, "_load_state"}, state, 1);
        check({name, "_load_busy"}, busy, 1);
        check({name, "_load_hits"}, hits, 0);
        check({name, "_load_valid"}, valid, 0);
        pend = tick;
        lat = 1; emitted = 0; held = 0; fin = 0; cyc = 0; last_b = 1'b0;
        while (!fin && cyc < 2000) begin
            if (poke) begin
                start   = 1'($urandom_range(0, 1));
                pattern = PW'($urandom);
                len     = 4'($urandom);
            end
            @(negedge clk);
            cyc++;
            if (pend) begin
                if (exp_q.size() > 0) begin
                    last_b = exp_q.pop_front();
                    if (emitted == 0) check({name, "_first_latency_ok"}, (lat >= 1 && lat <= DIV), 1);
                    else              check({name, "_bit_hold"}, held, DIV);
                    check({name, "_out"}, out, last_b);
                    check({name, "_valid"}, valid, 1);
                    check({name, "_busy"}, busy, 1);
                    emitted++;
                    held = 1;
                    if (emitted % l == 0) rpt = (emitted < l * (nrep + 1));
                    else                  rpt = 1'($urandom_range(0, 1));
                    if (abort_at != 0 && emitted == abort_at) begin
                        start = 1'b0;
                        rst   = 1'b1;
                        @(negedge clk);
                        check({name, "_abort_out"}, out, 0);
                        check({name, "_abort_valid"}, valid, 0);
                        check({name, "_abort_busy"}, busy, 0);
                        check({name, "_abort_hits"}, hits, 0);
                        check({name, "_abort_state"}, state, 0);
                        check({name, "_abort_done"}, done, 0);
                        @(negedge clk);
                        check({name, "_abort_done2"}, done, 0);
                        rst = 1'b0;
                        check_first_tick({name, "_abort"});
                        return;
                    end
                end else begin
                    start = 1'b0;
                    check({name, "_done_state"}, state, 3);
                    check({name, "_done_pulse"}, done, 1);
                    check({name, "_done_out"}, out, 0);
                    check({name, "_done_valid"}, valid, 0);
                    check({name, "_done_busy"}, busy, 0);
                    check({name, "_hits"}, hits, exp_hits);
                    fin = 1;
                end
            end else begin
                if (emitted == 0) begin
                    lat++;
                    check({name, "_wait_state"}, state, 1);
                end else begin
                    held++;
                    check({name, "_out_stable"}, out, last_b);
                    check({name, "_valid_held"}, valid, 1);
                end
                check({name, "_no_early_done"}, done, 0);
            end
            pend = tick;
        end
        if (!fin) begin
            check({name, "_timeout"}, 0, 1);
            start = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            return;
        end
        @(negedge clk);
        check({name, "_idle_state"}, state, 0);
        check({name, "_idle_done"}, done, 0);
        check({name, "_idle_busy"}, busy, 0);
        check({name, "_hits_hold"}, hits, exp_hits);
    endtask

    task automatic len_zero_start(input int cycles);
        start = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            pattern = PW'($urandom);
            len     = 4'd0;
            @(negedge clk);
            check("len0_state", state, 0);
            check("len0_done", done, 0);
            check("len0_busy", busy, 0);
        end
        start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] r6;
        rst     = 1'b1;
        start   = 1'b1;
        pattern = 8'hFF;
        len     = 4'd8;
        rpt     = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_out", out, 0);
            check("rst_valid", valid, 0);
            check("rst_tick", tick, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_state", state, 0);
            check("rst_hits", hits, 0);
        end
        rst   = 1'b0;
        start = 1'b0;
        check_first_tick("reset");

        send("basic", 8'hE7, 8, 0, 1'b0, 0);
        send("short", 8'hFD, 3, 0, 1'b0, 0);
        send("clamp", PW'($urandom), 12, 0, 1'b0, 0);
        r6 = 6'($urandom);
        send("repeat", {r6, 2'b11}, 2, 2, 1'b0, 0);
        len_zero_start(5);
        send("busy_start", PW'($urandom), 8, 1, 1'b1, 0);

        for (int t = 0; t < 8; t++) begin
            send("rand", PW'($urandom), $urandom_range(1, 15), $urandom_range(0, 2),
                 1'($urandom_range(0, 1)), 0);
        end

        send("abort", 8'hE7, 8, 0, 1'b0, 4);
        send("after_abort", 8'hB6, 8, 1, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
